spectrum_peak_detector: RTL and testbench



---
 rtl/spectrum_peak_detector.sv | 182 ++++++++++++++++++
 tb/tb_spectrum_peak_detector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_detector.sv
// spectrum_peak_detector: consumes one frame of magnitude bins from the Filter
// block, tracks the largest in-band bin and publishes its index and magnitude
// at frame end. done is high whenever a new frame can be accepted.
// Optional: define PEAK_STABLE_EN to qualify peak_valid with a count of
// consecutive frames that agree on the peak index.
module spectrum_peak_detector #(
  parameter int unsigned NUM_BINS      = 2048,
  parameter int unsigned MIN_BIN       = 2,
  parameter int unsigned MAX_BIN       = 1023,
  parameter logic [63:0] MAG_THRESH    = 64'd1024,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        mag_valid,
  input  logic [63:0] mag,
  input  logic [10:0] index,
  output logic        done,
  output logic [10:0] peak_index,
  output logic [63:0] peak_mag,
  output logic        peak_valid,
  output logic        frame_tick,
  output logic        overrun
);

  localparam int unsigned MAG_W = 64;
  localparam int unsigned IDX_W = 11;
  // One bit wider than the index so a count of NUM_BINS does not wrap.
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned AGR_W = 3;

  // Elaboration-time parameter sanity checks.
  if (STABLE_FRAMES > 7) begin : g_stable_range_err
    $error("STABLE_FRAMES must fit the 3-bit agreement counter");
  end
  if (MIN_BIN > MAX_BIN || MAX_BIN >= NUM_BINS || NUM_BINS > 2048) begin : g_bin_range_err
    $error("bin range parameters are inconsistent");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } state_e;

  state_e            state_q;
  logic [MAG_W-1:0]  max_q;
  logic [IDX_W-1:0]  cand_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              done_q;
  logic [IDX_W-1:0]  peak_index_q;
  logic [MAG_W-1:0]  peak_mag_q;
  logic              peak_valid_q;
  logic              frame_tick_q;
  logic              overrun_q;

  logic              in_band_c;
  logic              bigger_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              last_c;
  logic              raw_valid_c;
  logic              peak_valid_d;

  // Per-sample decode: band check, new-max check and end-of-frame detection.
  always_comb begin
    in_band_c   = (index >= IDX_W'(MIN_BIN)) && (index <= IDX_W'(MAX_BIN));
    bigger_c    = (mag > max_q);
    cnt_inc_c   = cnt_q + CNT_W'(1);
    last_c      = (index == IDX_W'(NUM_BINS - 1)) || (cnt_inc_c == CNT_W'(NUM_BINS));
    raw_valid_c = (max_q >= MAG_THRESH);
  end

`ifdef PEAK_STABLE_EN
  logic [AGR_W-1:0] agree_q;
  logic [AGR_W-1:0] agree_d;

  // Agreement counter update applied in REPORT; saturates at STABLE_FRAMES.
  always_comb begin
    agree_d = '0;
    if (raw_valid_c && (cand_q == peak_index_q)) begin
      if (agree_q >= AGR_W'(STABLE_FRAMES)) begin
        agree_d = AGR_W'(STABLE_FRAMES);
      end else begin
        agree_d = agree_q + AGR_W'(1);
      end
    end else if (raw_valid_c) begin
      agree_d = AGR_W'(1);
    end
    peak_valid_d = (agree_d >= AGR_W'(STABLE_FRAMES));
  end

  // Agreement counter register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      agree_q <= '0;
    end else if (state_q == S_REPORT) begin
      agree_q <= agree_d;
    end
  end
`else
  // Without stability qualification each frame stands on its own.
  always_comb begin
    peak_valid_d = raw_valid_c;
  end
`endif

  // Frame FSM with accumulators and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      max_q        <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b1;
      peak_index_q <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      frame_tick_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b1;
          if (mag_valid) begin
            overrun_q <= 1'b1;
          end
          if (start) begin
            state_q <= S_COLLECT;
            max_q   <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        S_COLLECT: begin
          done_q <= 1'b0;
          if (start) begin
            // Abort: restart the frame, ignore this cycle's sample.
            max_q  <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
          end else if (mag_valid) begin
            cnt_q <= cnt_inc_c;
            if (in_band_c && bigger_c) begin
              max_q  <= mag;
              cand_q <= index;
            end
            if (last_c) begin
              state_q <= S_REPORT;
            end
          end
        end
        S_REPORT: begin
          peak_index_q <= cand_q;
          peak_mag_q   <= max_q;
          peak_valid_q <= peak_valid_d;
          frame_tick_q <= 1'b1;
          done_q       <= 1'b1;
          state_q      <= S_IDLE;
          if (mag_valid) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign done       = done_q;
  assign peak_index = peak_index_q;
  assign peak_mag   = peak_mag_q;
  assign peak_valid = peak_valid_q;
  assign frame_tick = frame_tick_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spectrum_peak_detector.sv
// Testbench for spectrum_peak_detector: table-driven frames plus hand-written
// sequences for overrun, abort, mid-frame reset and (optionally) stability.
module tb_spectrum_peak_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mag_valid;
  logic [63:0] mag;
  logic [10:0] index;
  logic        done;
  logic [10:0] peak_index;
  logic [63:0] peak_mag;
  logic        peak_valid;
  logic        frame_tick;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  logic [10:0] m_prev;
  int          m_agree;

  typedef struct {
    int          pat;
    int          n;
    logic [10:0] idx;
    logic [63:0] pmag;
    logic        raw;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  spectrum_peak_detector dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .mag_valid  (mag_valid),
    .mag        (mag),
    .index      (index),
    .done       (done),
    .peak_index (peak_index),
    .peak_mag   (peak_mag),
    .peak_valid (peak_valid),
    .frame_tick (frame_tick),
    .overrun    (overrun)
  );

  always @(negedge clk) begin
    if (frame_tick === 1'b1) ticks++;
  end

  function automatic logic [63:0] bin_mag(input int pat, input int i);
    case (pat)
      0: return (i == 100) ? 64'd5000 : 64'd10;
      1: begin
        if (i == 0 || i == 1500) return 64'd1000000;
        if (i == 300) return 64'd900;
        return 64'd5;
      end
      2: return (i == 50 || i == 60) ? 64'd2000 : 64'd10;
      3: return (i == 7) ? 64'd3000 : 64'd10;
      4: return 64'd0;
      5: return (i == 200) ? 64'd5000 : 64'd10;
      6: return (i == 201) ? 64'd5000 : 64'd10;
      7: begin
        if (i == 1 || i == 1024) return 64'd50000;
        if (i == 1023) return 64'd1024;
        return 64'd10;
      end
      8: begin
        if (i == 2) return 64'd1023;
        if (i == 2047) return 64'd77777;
        return 64'd3;
      end
      9: return (i == 30) ? 64'd99999 : 64'd10;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected peak_valid for a completed frame, including stability history.
  task automatic model_valid(input logic raw, input logic [10:0] idx, output logic v);
`ifdef PEAK_STABLE_EN
    if (raw && idx == m_prev) m_agree = (m_agree >= 3) ? 3 : m_agree + 1;
    else m_agree = raw ? 1 : 0;
    v = (m_agree >= 3);
`else
    v = raw;
`endif
    m_prev = idx;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mag_valid = 1'b0; mag = '0; index = '0;
    cyc();
    reset = 1'b0;
    m_prev = '0;
    m_agree = 0;
  endtask

  // Drive n bins with index 0..n-1; if jump, the last bin carries index 2047.
  task automatic send_bins(input int pat, input int n, input bit jump);
    for (int i = 0; i < n; i++) begin
      mag_valid = 1'b1;
      index = (jump && i == n - 1) ? 11'd2047 : 11'(i);
      mag = bin_mag(pat, int'(index));
      cyc();
    end
    mag_valid = 1'b0;
    mag = '0;
    index = '0;
  endtask

  task automatic run_frame(input int pat, input int n, input logic [10:0] eidx,
                           input logic [63:0] emag, input logic raw);
    int t0;
    logic ev;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_low_collect", 64'(done), 64'd0);
    send_bins(pat, n, n < 2048);
    t0 = ticks;
    chk("tick_in_report", 64'(frame_tick), 64'd0);
    chk("done_in_report", 64'(done), 64'd0);
    cyc();
    model_valid(raw, eidx, ev);
    chk("frame_tick", 64'(frame_tick), 64'd1);
    chk("done_after", 64'(done), 64'd1);
    chk("peak_index", 64'(peak_index), 64'(eidx));
    chk("peak_mag", peak_mag, emag);
    chk("peak_valid", 64'(peak_valid), 64'(ev));
    cyc();
    chk("tick_one_cycle", 64'(frame_tick), 64'd0);
    chk("tick_count", 64'(ticks - t0), 64'd1);
  endtask

  initial begin
    int t0;
    logic ev;

    vecs[0] = '{0, 2048, 11'd100,  64'd5000, 1'b1};
    vecs[1] = '{1, 2048, 11'd300,  64'd900,  1'b0};
    vecs[2] = '{2, 2048, 11'd50,   64'd2000, 1'b1};
    vecs[3] = '{7, 2048, 11'd1023, 64'd1024, 1'b1};
    vecs[4] = '{8, 2048, 11'd2,    64'd1023, 1'b0};
    vecs[5] = '{4, 2048, 11'd0,    64'd0,    1'b0};
    vecs[6] = '{3, 100,  11'd7,    64'd3000, 1'b1};

    do_reset();
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_peak_index", 64'(peak_index), 64'd0);
    chk("rst_peak_mag", peak_mag, 64'd0);
    chk("rst_peak_valid", 64'(peak_valid), 64'd0);
    chk("rst_frame_tick", 64'(frame_tick), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].pat, vecs[v].n, vecs[v].idx, vecs[v].pmag, vecs[v].raw);
    end
    chk("overrun_clean", 64'(overrun), 64'd0);

    // Stray sample while idle sets the sticky overrun flag.
    mag_valid = 1'b1; index = 11'd5; mag = 64'd123;
    cyc();
    mag_valid = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    run_frame(0, 2048, 11'd100, 64'd5000, 1'b1);
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Abort after 500 bins; the restart-cycle sample must be ignored.
    t0 = ticks;
    start = 1'b1;
    cyc();
    start = 1'b0;
    send_bins(9, 500, 1'b0);
    start = 1'b1; mag_valid = 1'b1; index = 11'd10; mag = 64'd88888;
    cyc();
    start = 1'b0; mag_valid = 1'b0; mag = '0; index = '0;
    send_bins(3, 2048, 1'b0);
    cyc();
    cyc();
    cyc();
    model_valid(1'b1, 11'd7, ev);
    chk("abort_tick_count", 64'(ticks - t0), 64'd1);
    chk("abort_peak_index", 64'(peak_index), 64'd7);
    chk("abort_peak_mag", peak_mag, 64'd3000);
    chk("abort_peak_valid", 64'(peak_valid), 64'(ev));

    // Reset in the middle of a frame.
    start = 1'b1;
    cyc();
    start = 1'b0;
    send_bins(0, 200, 1'b0);
    t0 = ticks;
    do_reset();
    chk("midrst_done", 64'(done), 64'd1);
    chk("midrst_peak_index", 64'(peak_index), 64'd0);
    chk("midrst_peak_mag", peak_mag, 64'd0);
    chk("midrst_peak_valid", 64'(peak_valid), 64'd0);
    chk("midrst_overrun", 64'(overrun), 64'd0);
    for (int i = 0; i < 6; i++) cyc();
    chk("midrst_no_tick", 64'(ticks - t0), 64'd0);
    chk("midrst_idle_done", 64'(done), 64'd1);
    chk("midrst_no_overrun", 64'(overrun), 64'd0);

`ifdef PEAK_STABLE_EN
    do_reset();
    run_frame(5, 2048, 11'd200, 64'd5000, 1'b1);
    chk("stable_f1", 64'(peak_valid), 64'd0);
    run_frame(5, 2048, 11'd200, 64'd5000, 1'b1);
    chk("stable_f2", 64'(peak_valid), 64'd0);
    run_frame(5, 2048, 11'd200, 64'd5000, 1'b1);
    chk("stable_f3", 64'(peak_valid), 64'd1);
    run_frame(6, 2048, 11'd201, 64'd5000, 1'b1);
    chk("stable_f4", 64'(peak_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
